// File: rtl/sipo_if.sv
// Serial-in / parallel-out handshake bundle: serial word input side and assembled vector output side.
interface sipo_if #(
    parameter int unsigned PE_NUM     = 4,
    parameter int unsigned DATA_WIDTH = 16
);
    localparam int unsigned W  = 2 * DATA_WIDTH;
    localparam int unsigned VW = PE_NUM * W;

    logic          s_in_v;
    logic [W-1:0]  s_in;
    logic          s_in_rdy;
    logic          p_out_v;
    logic [VW-1:0] p_out;
    logic          p_out_rdy;

    modport master (
        output s_in_v, s_in, p_out_rdy,
        input  s_in_rdy, p_out_v, p_out
    );

    modport slave (
        input  s_in_v, s_in, p_out_rdy,
        output s_in_rdy, p_out_v, p_out
    );
endinterface

// File: rtl/sipo.sv
// Collects PE_NUM serial words into one parallel vector; word 0 lands in the most significant slot.
module sipo #(
    parameter int unsigned PE_NUM     = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  ce,
    input  logic  clr,
    sipo_if.slave bus
);
    localparam int unsigned W     = 2 * DATA_WIDTH;
    localparam int unsigned VW    = PE_NUM * W;
    localparam int unsigned BW    = (PE_NUM - 1) * W;
    localparam int unsigned CNT_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PE_NUM - 1);

    logic [CNT_W-1:0] cnt, cnt_nxt, slot_c;
    logic [BW-1:0]    buf_q, buf_nxt;
    logic [VW-1:0]    p_out_q, p_out_nxt;
    logic             p_out_v_q, p_out_v_nxt;
    logic             rdy_c, accept_c, complete_c;

    // Accept/complete decode and next-state for counter, buffer and output register
    always_comb begin
        slot_c      = clr ? '0 : cnt;
        rdy_c       = !((cnt == LAST) && p_out_v_q && !bus.p_out_rdy);
        accept_c    = ce && bus.s_in_v && rdy_c;
        complete_c  = accept_c && (slot_c == LAST);
        cnt_nxt     = cnt;
        buf_nxt     = buf_q;
        p_out_nxt   = p_out_q;
        p_out_v_nxt = p_out_v_q;
        if (ce) begin
            if (clr) begin
                cnt_nxt = '0;
            end
            if (p_out_v_q && bus.p_out_rdy) begin
                p_out_v_nxt = 1'b0;
            end
            if (complete_c) begin
                cnt_nxt     = '0;
                p_out_nxt   = {buf_q, bus.s_in};
                p_out_v_nxt = 1'b1;
            end else if (accept_c) begin
                cnt_nxt = slot_c + CNT_W'(1);
                for (int unsigned k = 0; k < PE_NUM - 1; k++) begin
                    if (slot_c == CNT_W'(k)) begin
                        buf_nxt[BW - (k + 1) * W +: W] = bus.s_in;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            buf_q     <= '0;
            p_out_q   <= '0;
            p_out_v_q <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            buf_q     <= buf_nxt;
            p_out_q   <= p_out_nxt;
            p_out_v_q <= p_out_v_nxt;
        end
    end

    // Ready is combinational so a drain and a refill can share an edge
    assign bus.s_in_rdy = rdy_c;
    assign bus.p_out_v  = p_out_v_q;
    assign bus.p_out    = p_out_q;
endmodule

// File: tb/tb_sipo.sv
// Scoreboard bench for sipo: a word-level model builds expected vectors, a monitor records drained ones.
module tb_sipo;
    localparam int unsigned PE_NUM     = 4;
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned W          = 2 * DATA_WIDTH;
    localparam int unsigned VW         = PE_NUM * W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ce  = 1'b0;
    logic clr = 1'b0;

    sipo_if #(.PE_NUM(PE_NUM), .DATA_WIDTH(DATA_WIDTH)) bus ();

    sipo #(.PE_NUM(PE_NUM), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0]  asm_q[$];
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] obs_q[$];
    time           obs_t[$];

    // Record every vector that the next rising edge hands downstream
    always @(negedge clk) begin
        if (rst && ce && bus.p_out_v && bus.p_out_rdy) begin
            obs_q.push_back(bus.p_out);
            obs_t.push_back($time);
        end
    end

    // Offer one word until accepted; on acceptance update the reference vector model
    task automatic send(input logic [W-1:0] w, input logic c, output int waits);
        logic          acc;
        logic [VW-1:0] v;
        bus.s_in_v = 1'b1;
        bus.s_in   = w;
        clr        = c;
        waits      = 0;
        acc        = 1'b0;
        while (!acc && waits < 20) begin
            @(negedge clk);
            acc = bus.s_in_rdy;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        clr = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_timeout: word %h accepted=%0b required=1", w, acc);
        end else begin
            if (c) asm_q.delete();
            asm_q.push_back(w);
            if (asm_q.size() == PE_NUM) begin
                v = '0;
                foreach (asm_q[i]) v = {v[VW-W-1:0], asm_q[i]};
                exp_q.push_back(v);
                asm_q.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        bus.s_in_v = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.s_in_v    = 1'b0;
        bus.s_in      = '0;
        bus.p_out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.p_out_v, bus.s_in_rdy} !== 2'b01 || bus.p_out !== '0) begin
            n_fail++;
            $display("FAIL reset_state: v=%b rdy=%b p_out=%h required v=0 rdy=1 p_out=0",
                     bus.p_out_v, bus.s_in_rdy, bus.p_out);
        end
        rst = 1'b1;
        ce  = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.p_out_v !== 1'b0 || bus.s_in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: v=%b rdy=%b required v=0 rdy=1", bus.p_out_v, bus.s_in_rdy);
        end
    endtask

    task automatic test_basic();
        int            wt;
        logic [VW-1:0] e, o;
        bus.p_out_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) send(32'(i), 1'b0, wt);
        n_checks++;
        if (bus.p_out_v !== 1'b1 || bus.p_out !== 128'h00000001_00000002_00000003_00000004) begin
            n_fail++;
            $display("FAIL basic_vector: v=%b p_out=%h required v=1 p_out=00000001000000020000000300000004",
                     bus.p_out_v, bus.p_out);
        end
        idle(1);
        n_checks++;
        if (bus.p_out_v !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_single_cycle: v=%b required 0", bus.p_out_v);
        end
        while (exp_q.size() > 0) begin
            n_checks++;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL basic_sb: no vector observed, required %h", e);
            end else begin
                o = obs_q.pop_front();
                void'(obs_t.pop_front());
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL basic_sb: got %h required %h", o, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int            wt, total;
        time           t0, t1;
        logic [VW-1:0] e, o;
        logic [W-1:0]  words[8];
        words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                  32'h00000011, 32'h00000022, 32'h00000033, 32'h00000044};
        bus.p_out_rdy = 1'b1;
        total = 0;
        foreach (words[i]) begin
            send(words[i], 1'b0, wt);
            total += wt;
        end
        idle(2);
        n_checks++;
        if (total !== 0) begin
            n_fail++;
            $display("FAIL b2b_no_stall: stall cycles %0d required 0", total);
        end
        n_checks++;
        if (obs_t.size() < 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: %0d vectors observed required 2", obs_t.size());
        end else begin
            t0 = obs_t[0];
            t1 = obs_t[1];
            if (t1 - t0 !== 40) begin
                n_fail++;
                $display("FAIL b2b_spacing: gap %0t required 40", t1 - t0);
            end
        end
        obs_t.delete();
        while (exp_q.size() > 0) begin
            n_checks++;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_sb: no vector observed, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL b2b_sb: got %h required %h", o, e);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int            wt, total;
        logic [VW-1:0] e, o;
        bus.p_out_rdy = 1'b0;
        total = 0;
        for (int i = 1; i <= 7; i++) begin
            send(32'hB000_0000 + 32'(i), 1'b0, wt);
            total += wt;
        end
        n_checks++;
        if (total !== 0) begin
            n_fail++;
            $display("FAIL bp_early_stall: stall cycles %0d required 0", total);
        end
        bus.s_in_v = 1'b1;
        bus.s_in   = 32'hB000_0008;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.s_in_rdy !== 1'b0 || bus.p_out_v !== 1'b1 ||
                bus.p_out !== 128'hB0000001_B0000002_B0000003_B0000004) begin
                n_fail++;
                $display("FAIL bp_hold: rdy=%b v=%b p_out=%h required rdy=0 v=1 p_out=B0000001B0000002B0000003B0000004",
                         bus.s_in_rdy, bus.p_out_v, bus.p_out);
            end
            @(posedge clk);
            #1;
        end
        bus.p_out_rdy = 1'b1;
        send(32'hB000_0008, 1'b0, wt);
        n_checks++;
        if (wt !== 0 || bus.p_out_v !== 1'b1 || bus.p_out !== 128'hB0000005_B0000006_B0000007_B0000008) begin
            n_fail++;
            $display("FAIL bp_release: waits=%0d v=%b p_out=%h required waits=0 v=1 p_out=B0000005B0000006B0000007B0000008",
                     wt, bus.p_out_v, bus.p_out);
        end
        idle(2);
        obs_t.delete();
        while (exp_q.size() > 0) begin
            n_checks++;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL bp_sb: no vector observed, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL bp_sb: got %h required %h", o, e);
                end
            end
        end
    endtask

    task automatic test_clr();
        int            wt;
        logic [VW-1:0] e, o;
        bus.p_out_rdy = 1'b1;
        send(32'h000000C1, 1'b0, wt);
        send(32'h000000C2, 1'b0, wt);
        send(32'hAAAAAAAA, 1'b1, wt);
        for (int i = 1; i <= 3; i++) send(32'h000000D0 + 32'(i), 1'b0, wt);
        n_checks++;
        if (bus.p_out_v !== 1'b1 || bus.p_out !== 128'hAAAAAAAA_000000D1_000000D2_000000D3) begin
            n_fail++;
            $display("FAIL clr_vector: v=%b p_out=%h required v=1 p_out=AAAAAAAA000000D1000000D2000000D3",
                     bus.p_out_v, bus.p_out);
        end
        idle(2);
        obs_t.delete();
        while (exp_q.size() > 0) begin
            n_checks++;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL clr_sb: no vector observed, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL clr_sb: got %h required %h", o, e);
                end
            end
        end
    endtask

    task automatic test_ce_reset();
        int            wt;
        logic [VW-1:0] e, o;
        // Hold a full vector with two words of the next one pending, then freeze
        bus.p_out_rdy = 1'b0;
        for (int i = 1; i <= 6; i++) send(32'hE000_0000 + 32'(i), 1'b0, wt);
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.s_in_v    = ~bus.s_in_v;
            bus.s_in      = $urandom;
            clr           = ~clr;
            bus.p_out_rdy = 1'b1;
            @(negedge clk);
            n_checks++;
            if (bus.p_out_v !== 1'b1 || bus.s_in_rdy !== 1'b1 ||
                bus.p_out !== 128'hE0000001_E0000002_E0000003_E0000004) begin
                n_fail++;
                $display("FAIL ce_freeze: v=%b rdy=%b p_out=%h required v=1 rdy=1 p_out=E0000001E0000002E0000003E0000004",
                         bus.p_out_v, bus.s_in_rdy, bus.p_out);
            end
            @(posedge clk);
            #1;
        end
        clr = 1'b0;
        ce  = 1'b1;
        send(32'hE000_0007, 1'b0, wt);
        send(32'hE000_0008, 1'b0, wt);
        n_checks++;
        if (bus.p_out_v !== 1'b1 || bus.p_out !== 128'hE0000005_E0000006_E0000007_E0000008) begin
            n_fail++;
            $display("FAIL ce_resume: v=%b p_out=%h required v=1 p_out=E0000005E0000006E0000007E0000008",
                     bus.p_out_v, bus.p_out);
        end
        idle(2);

        // Reset with a held vector and a partial one pending
        bus.p_out_rdy = 1'b0;
        for (int i = 1; i <= 6; i++) send(32'hF000_0000 + 32'(i), 1'b0, wt);
        #2;
        rst = 1'b0;
        asm_q.delete();
        void'(exp_q.pop_back());
        #1;
        n_checks++;
        if (bus.p_out_v !== 1'b0 || bus.p_out !== '0 || bus.s_in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async: v=%b rdy=%b p_out=%h required v=0 rdy=1 p_out=0",
                     bus.p_out_v, bus.s_in_rdy, bus.p_out);
        end
        bus.s_in_v    = 1'b0;
        bus.p_out_rdy = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) send(32'h5000_0000 + 32'(i), 1'b0, wt);
        n_checks++;
        if (bus.p_out_v !== 1'b1 || bus.p_out !== 128'h50000001_50000002_50000003_50000004) begin
            n_fail++;
            $display("FAIL rst_clean_vector: v=%b p_out=%h required v=1 p_out=50000001500000025000000350000004",
                     bus.p_out_v, bus.p_out);
        end
        idle(2);
        obs_t.delete();
        while (exp_q.size() > 0) begin
            n_checks++;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL ce_rst_sb: no vector observed, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL ce_rst_sb: got %h required %h", o, e);
                end
            end
        end
        n_checks++;
        if (obs_q.size() !== 0) begin
            n_fail++;
            $display("FAIL extra_vectors: %0d unexpected vectors, required 0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_clr();
        test_ce_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
